k2red_rr_sched: RTL and testbench

- Round-robin scheduler that shares one K2-RED Proth-prime reduction pipeline between NUM_REQ requesters.
- Per cycle, arbitrates among requester products, issues at most one 2*LOG_Q-bit operand to the reducer, and tracks the requester ID through the fixed reducer latency.
- Routes each reduced result back to the requester that issued it.
- Owns the modulus configuration (Q, l1, l2, l3) and applies any change only after the reducer pipeline has drained.

---
 rtl/k2red_rr_sched.sv | 239 +++++++++++++++++++++++
 tb/tb_k2red_rr_sched.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/k2red_rr_sched.sv
// ---------------------------------------------------------------------------
// k2red_rr_sched
//
// Shares one K2-RED Proth-prime reduction pipeline between NUM_REQ
// requesters. Each cycle a round-robin arbiter may accept one 2*LOG_Q-bit
// product. The accepted product is issued to the reducer on the next cycle.
// A tag shift register carries the requester ID alongside it through the
// fixed reducer latency, and each reduced result is returned to the
// requester that issued it. The modulus configuration (Q, l1, l2, l3) is
// held in this block. A new configuration is first latched into a shadow
// register and is applied only after every in-flight result has returned.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid/req_a   per-requester operand valid and flattened operands
//                     (requester i at bits [i*2*LOG_Q +: 2*LOG_Q])
//   req_ready         one-hot grant (combinational, independent of req_a)
//   cfg_we, cfg_*     configuration write pulse and new Q/l1/l2/l3
//   cfg_busy          high while a configuration is pending or not loaded
//   red_*             operand, modulus, shifts and valid sent to the reducer
//   red_c2/red_valid_out  result and valid returned by the reducer
//   rsp_valid         one-hot result strobe
//   rsp_data          result, shared by all requesters
//   err               sticky flag for a mismatch between reducer valid and tag
// ---------------------------------------------------------------------------
module k2red_rr_sched #(
  parameter int LOG_Q   = 32,
  parameter int LOG_L   = 4,
  parameter int NUM_REQ = 4,
  parameter int LOG_N   = 2,
  parameter int RED_LAT = 7
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*2*LOG_Q-1:0]  req_a,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic                        cfg_we,
  input  logic [LOG_Q-1:0]            cfg_q,
  input  logic [LOG_L-1:0]            cfg_l1,
  input  logic [LOG_L-1:0]            cfg_l2,
  input  logic [LOG_L-1:0]            cfg_l3,
  output logic                        cfg_busy,
  output logic [2*LOG_Q-1:0]          red_a,
  output logic [LOG_Q-1:0]            red_q,
  output logic [LOG_L-1:0]            red_l1,
  output logic [LOG_L-1:0]            red_l2,
  output logic [LOG_L-1:0]            red_l3,
  output logic                        red_valid,
  input  logic [LOG_Q-1:0]            red_c2,
  input  logic                        red_valid_out,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [LOG_Q-1:0]            rsp_data,
  output logic                        err
);

  localparam int OP_W  = 2 * LOG_Q;
  localparam int CNT_W = $clog2(RED_LAT + 2);

  typedef enum logic [1:0] {ST_UNCFG, ST_RUN, ST_DRAIN, ST_LOAD} state_e;

  typedef struct packed {
    logic [LOG_Q-1:0] q;
    logic [LOG_L-1:0] l1;
    logic [LOG_L-1:0] l2;
    logic [LOG_L-1:0] l3;
  } cfg_t;

  state_e                       state_q, state_d;
  logic                         cfg_busy_q, cfg_busy_d;
  cfg_t                         shadow_q, shadow_d;
  cfg_t                         active_q, active_d;
  cfg_t                         cfg_new;
  logic [LOG_N-1:0]             ptr_q, ptr_d;
  logic [CNT_W-1:0]             inflight_q, inflight_d;
  logic [CNT_W-1:0]             quiet_q, quiet_d;
  logic                         red_valid_q, red_valid_d;
  logic [OP_W-1:0]              red_a_q, red_a_d;
  logic [LOG_N-1:0]             issue_id_q, issue_id_d;
  logic [RED_LAT-1:0]           tag_v_q, tag_v_d;
  logic [RED_LAT-1:0][LOG_N-1:0] tag_id_q, tag_id_d;
  logic [NUM_REQ-1:0]           rsp_valid_q, rsp_valid_d;
  logic [LOG_Q-1:0]             rsp_data_q, rsp_data_d;
  logic                         err_q, err_d;

  logic                         grant_found;
  logic [LOG_N-1:0]             grant_idx;
  logic [LOG_N-1:0]             scan_idx;
  logic                         handshake;
  logic                         head_live;
  logic                         out_seen;
  logic                         rsp_fire;
  logic                         dec;

  assign cfg_new = '{q: cfg_q, l1: cfg_l1, l2: cfg_l2, l3: cfg_l3};

  // Round-robin search starting at ptr_q. The grant depends only on
  // req_valid, the pointer and the state, never on the operand bits.
  // NOTE: every variable in an always_comb gets a default on entry, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = LOG_N'((int'(ptr_q) + k) % NUM_REQ);
      if (!grant_found && req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  assign handshake = (state_q == ST_RUN) && grant_found;
  assign req_ready = handshake ? (NUM_REQ'(1) << grant_idx) : '0;

  // After reset the reducer may still emit results for operands issued
  // before reset. For RED_LAT+1 cycles after reset those results are
  // ignored. That is long enough to flush the reducer, and no newly issued
  // operand can return within that time.
  assign head_live = tag_v_q[RED_LAT-1];
  assign out_seen  = red_valid_out && (quiet_q == '0);
  assign rsp_fire  = out_seen && head_live;
  assign dec       = out_seen && (inflight_q != '0);

  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    active_d    = active_q;
    ptr_d       = ptr_q;
    red_valid_d = handshake;
    red_a_d     = red_a_q;
    issue_id_d  = '0;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;

    case (state_q)
      ST_UNCFG: begin
        if (cfg_we) begin
          shadow_d = cfg_new;
          state_d  = ST_LOAD;
        end
      end
      ST_RUN: begin
        if (cfg_we) begin
          shadow_d = cfg_new;
          state_d  = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (cfg_we) shadow_d = cfg_new;
        if (inflight_q == '0) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        // A write arriving in the LOAD cycle is the newest one, so it is
        // applied directly instead of the shadow value it replaces.
        active_d = cfg_we ? cfg_new : shadow_q;
        shadow_d = active_d;
        state_d  = ST_RUN;
      end
      default: state_d = ST_UNCFG;
    endcase

    if (handshake) begin
      red_a_d    = req_a[int'(grant_idx)*OP_W +: OP_W];
      issue_id_d = grant_idx;
      ptr_d      = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
    end

    // The issue register {red_valid_q, issue_id_q} is the first stage of the
    // tag pipe. The head entry lines up with red_valid_out for that operand.
    tag_v_d  = {tag_v_q[RED_LAT-2:0], red_valid_q};
    tag_id_d = {tag_id_q[RED_LAT-2:0], issue_id_q};

    if (rsp_fire) begin
      rsp_valid_d = NUM_REQ'(1) << tag_id_q[RED_LAT-1];
      rsp_data_d  = red_c2;
    end

    cfg_busy_d = (state_d != ST_RUN);
    inflight_d = inflight_q + CNT_W'(handshake) - CNT_W'(dec);
    quiet_d    = (quiet_q == '0) ? '0 : quiet_q - 1'b1;
    err_d      = err_q | ((quiet_q == '0) && (red_valid_out != head_live));
  end

  // NOTE: all state is updated with non-blocking assignments. Every flop
  // then samples its _d value from before the edge, whatever the order of
  // the statements.
  // NOTE: the tag pipe is reset along with the control state. A stale tag
  // left over from before reset would otherwise send a result to the wrong
  // requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_UNCFG;
      cfg_busy_q  <= 1'b1;
      shadow_q    <= '0;
      active_q    <= '0;
      ptr_q       <= '0;
      inflight_q  <= '0;
      quiet_q     <= CNT_W'(RED_LAT + 1);
      red_valid_q <= 1'b0;
      red_a_q     <= '0;
      issue_id_q  <= '0;
      tag_v_q     <= '0;
      tag_id_q    <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_busy_q  <= cfg_busy_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      ptr_q       <= ptr_d;
      inflight_q  <= inflight_d;
      quiet_q     <= quiet_d;
      red_valid_q <= red_valid_d;
      red_a_q     <= red_a_d;
      issue_id_q  <= issue_id_d;
      tag_v_q     <= tag_v_d;
      tag_id_q    <= tag_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      err_q       <= err_d;
    end
  end

  assign cfg_busy  = cfg_busy_q;
  assign red_valid = red_valid_q;
  assign red_a     = red_a_q;
  assign red_q     = active_q.q;
  assign red_l1    = active_q.l1;
  assign red_l2    = active_q.l2;
  assign red_l3    = active_q.l3;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign err       = err_q;

endmodule

// File: tb/tb_k2red_rr_sched.sv
// ---------------------------------------------------------------------------
// tb_k2red_rr_sched
//
// Bench for k2red_rr_sched. A reducer stand-in returns (a mod q) after
// RED_LAT cycles. It is not reset, so results issued before a reset still
// arrive afterwards. A behavioural model turns the scheduler rules into a
// list of expected responses and a few expected status values. One negedge
// process compares every DUT output with that model on every cycle. The
// stimulus process adds a few hand-computed literal checks.
// ---------------------------------------------------------------------------
module tb_k2red_rr_sched;

  localparam int LOG_Q   = 32;
  localparam int LOG_L   = 4;
  localparam int NUM_REQ = 4;
  localparam int LOG_N   = 2;
  localparam int RED_LAT = 7;
  localparam int OP_W    = 2 * LOG_Q;

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b0;
  logic [NUM_REQ-1:0]         req_valid = '0;
  logic [NUM_REQ*OP_W-1:0]    req_a = '0;
  logic [NUM_REQ-1:0]         req_ready;
  logic                       cfg_we = 1'b0;
  logic [LOG_Q-1:0]           cfg_q = '0;
  logic [LOG_L-1:0]           cfg_l1 = '0, cfg_l2 = '0, cfg_l3 = '0;
  logic                       cfg_busy;
  logic [OP_W-1:0]            red_a;
  logic [LOG_Q-1:0]           red_q;
  logic [LOG_L-1:0]           red_l1, red_l2, red_l3;
  logic                       red_valid;
  logic [LOG_Q-1:0]           red_c2;
  logic                       red_valid_out;
  logic [NUM_REQ-1:0]         rsp_valid;
  logic [LOG_Q-1:0]           rsp_data;
  logic                       err;
  logic                       inject = 1'b0;

  int checks = 0;
  int errors = 0;

  k2red_rr_sched #(
    .LOG_Q(LOG_Q), .LOG_L(LOG_L), .NUM_REQ(NUM_REQ), .LOG_N(LOG_N), .RED_LAT(RED_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_a(req_a), .req_ready(req_ready),
    .cfg_we(cfg_we), .cfg_q(cfg_q), .cfg_l1(cfg_l1), .cfg_l2(cfg_l2), .cfg_l3(cfg_l3),
    .cfg_busy(cfg_busy),
    .red_a(red_a), .red_q(red_q), .red_l1(red_l1), .red_l2(red_l2), .red_l3(red_l3),
    .red_valid(red_valid), .red_c2(red_c2), .red_valid_out(red_valid_out),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .err(err)
  );

  always #5 clk = ~clk;

  // Reducer stand-in: a plain RED_LAT-cycle delay line of (a mod q).
  logic [RED_LAT-1:0] rm_v = '0;
  logic [LOG_Q-1:0]   rm_d [RED_LAT];

  always @(posedge clk) begin
    rm_v    <= {rm_v[RED_LAT-2:0], red_valid};
    rm_d[0] <= (red_q != '0) ? LOG_Q'(red_a % OP_W'(red_q)) : '0;
    for (int i = 1; i < RED_LAT; i++) rm_d[i] <= rm_d[i-1];
  end

  assign red_valid_out = rm_v[RED_LAT-1] | inject;
  assign red_c2        = rm_d[RED_LAT-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int M_UNCFG = 0, M_RUN = 1, M_DRAIN = 2, M_LOAD = 3;

  typedef struct {
    int               id;
    logic [LOG_Q-1:0] data;
    int               due;
  } exp_t;

  exp_t             pend[$];
  int               cyc = 0;
  int               m_mode;
  int               m_ptr;
  bit               m_issue;
  bit               m_err;
  logic [OP_W-1:0]  m_red_a;
  logic [LOG_Q-1:0] m_rsp_data;
  logic [LOG_Q-1:0] m_q, sh_q;
  logic [LOG_L-1:0] m_l1, m_l2, m_l3, sh_l1, sh_l2, sh_l3;

  function automatic int first_req(input logic [NUM_REQ-1:0] v, input int from);
    for (int k = 0; k < NUM_REQ; k++)
      if (v[(from + k) % NUM_REQ]) return (from + k) % NUM_REQ;
    return -1;
  endfunction

  task automatic model_reset();
    pend.delete();
    m_mode = M_UNCFG; m_ptr = 0; m_issue = 0; m_err = 0;
    m_red_a = '0; m_rsp_data = '0;
    m_q = '0; m_l1 = '0; m_l2 = '0; m_l3 = '0;
    sh_q = '0; sh_l1 = '0; sh_l2 = '0; sh_l3 = '0;
  endtask

  task automatic take_cfg();
    sh_q = cfg_q; sh_l1 = cfg_l1; sh_l2 = cfg_l2; sh_l3 = cfg_l3;
  endtask

  always @(negedge clk) begin
    int g;
    logic [NUM_REQ-1:0] exp_rdy;
    logic [NUM_REQ-1:0] exp_rsp;
    exp_t e;

    if (!rst_n) model_reset();
    g       = (m_mode == M_RUN) ? first_req(req_valid, m_ptr) : -1;
    exp_rdy = (g >= 0) ? (NUM_REQ'(1) << g) : '0;
    exp_rsp = '0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      exp_rsp    = NUM_REQ'(1) << pend[0].id;
      m_rsp_data = pend[0].data;
      void'(pend.pop_front());
    end

    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    check("cfg_busy", 64'(cfg_busy), 64'(m_mode != M_RUN));
    check("red_valid", 64'(red_valid), 64'(m_issue));
    check("red_a", red_a, m_red_a);
    check("red_q", 64'(red_q), 64'(m_q));
    check("red_l", 64'({red_l1, red_l2, red_l3}), 64'({m_l1, m_l2, m_l3}));
    check("rsp_valid", 64'(rsp_valid), 64'(exp_rsp));
    check("rsp_data", 64'(rsp_data), 64'(m_rsp_data));
    check("err", 64'(err), 64'(m_err));

    if (rst_n) begin
      if (g >= 0) begin
        e.id   = g;
        e.data = LOG_Q'(req_a[g*OP_W +: OP_W] % OP_W'(m_q));
        e.due  = cyc + RED_LAT + 2;
        pend.push_back(e);
        m_ptr   = (g + 1) % NUM_REQ;
        m_red_a = req_a[g*OP_W +: OP_W];
        m_issue = 1;
      end else begin
        m_issue = 0;
      end
      if (inject) m_err = 1;
      case (m_mode)
        M_UNCFG: if (cfg_we) begin take_cfg(); m_mode = M_LOAD; end
        M_RUN:   if (cfg_we) begin take_cfg(); m_mode = M_DRAIN; end
        M_DRAIN: begin
          if (cfg_we) take_cfg();
          if (pend.size() == 0) m_mode = M_LOAD;
        end
        default: begin
          if (cfg_we) take_cfg();
          m_q = sh_q; m_l1 = sh_l1; m_l2 = sh_l2; m_l3 = sh_l3;
          m_mode = M_RUN;
        end
      endcase
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NUM_REQ; i++) req_a[i*OP_W +: OP_W] = {$urandom, $urandom};
  endtask

  task automatic write_cfg(input logic [LOG_Q-1:0] q, input logic [LOG_L-1:0] l1,
                           input logic [LOG_L-1:0] l2, input logic [LOG_L-1:0] l3);
    cfg_q = q; cfg_l1 = l1; cfg_l2 = l2; cfg_l3 = l3; cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Unconfigured: no grants even with every requester valid.
    req_valid = '1;
    #1 check("uncfg_no_grant", 64'(req_ready), 64'(0));
    req_valid = '0;
    tick();

    // Initial configuration: busy for the LOAD cycle, then clear.
    write_cfg(32'h8002_0001, 4'd0, 4'd0, 4'd0);
    check("cfg_busy_load", 64'(cfg_busy), 64'(1));
    tick();
    check("cfg_busy_run", 64'(cfg_busy), 64'(0));

    // Single requester 2; literal result 0x1_0000_0005 mod 0x80020001.
    req_valid = 4'b0100;
    req_a[2*OP_W +: OP_W] = 64'h0000_0001_0000_0005;
    tick();
    req_valid = '0;
    check("issue_valid", 64'(red_valid), 64'(1));
    check("issue_a", red_a, 64'h0000_0001_0000_0005);
    repeat (8) tick();
    check("req2_rsp_valid", 64'(rsp_valid), 64'(4'b0100));
    check("req2_rsp_data", 64'(rsp_data), 64'h7FFE_0004);
    tick();

    // All requesters valid for 12 cycles; pointer is at 3 after requester 2.
    for (int k = 0; k < 12; k++) begin
      req_valid = '1;
      rand_ops();
      #1 check("rr_order", 64'(req_ready), 64'(NUM_REQ'(1) << ((3 + k) % NUM_REQ)));
      tick();
    end
    req_valid = '0;
    repeat (12) tick();

    // Reconfigure with operations in flight; requests stay valid throughout.
    for (int k = 0; k < 5; k++) begin
      req_valid = 4'($urandom_range(1, 15));
      rand_ops();
      tick();
    end
    check("old_q_kept", 64'(red_q), 64'h8002_0001);
    req_valid = '1;
    write_cfg(32'hC000_0001, 4'd3, 4'd5, 4'd7);
    for (int k = 0; k < 15; k++) begin
      rand_ops();
      tick();
    end
    check("new_q_applied", 64'(red_q), 64'hC000_0001);
    req_valid = '0;
    repeat (12) tick();

    // Spurious reducer valid with nothing in flight.
    inject = 1'b1;
    tick();
    inject = 1'b0;
    check("err_set", 64'(err), 64'(1));
    repeat (3) tick();
    check("err_sticky", 64'(err), 64'(1));

    // Reset with three operations in flight.
    req_valid = '1;
    for (int k = 0; k < 3; k++) begin
      rand_ops();
      tick();
    end
    req_valid = '0;
    tick();
    rst_n = 1'b0;
    #1;
    check("rst_red_valid", 64'(red_valid), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    check("rst_cfg_busy", 64'(cfg_busy), 64'(1));
    check("rst_red_q", 64'(red_q), 64'(0));
    repeat (2) tick();
    rst_n = 1'b1;
    req_valid = '1;
    repeat (15) tick();
    req_valid = '0;

    // Randomized traffic with occasional reconfiguration.
    write_cfg($urandom | 32'h8000_0001, 4'($urandom), 4'($urandom), 4'($urandom));
    for (int k = 0; k < 400; k++) begin
      req_valid = 4'($urandom);
      rand_ops();
      if (!cfg_busy && $urandom_range(0, 39) == 0) begin
        cfg_q  = $urandom | 32'h8000_0001;
        cfg_l1 = 4'($urandom); cfg_l2 = 4'($urandom); cfg_l3 = 4'($urandom);
        cfg_we = 1'b1;
      end else begin
        cfg_we = 1'b0;
      end
      tick();
    end
    cfg_we = 1'b0;
    req_valid = '0;
    repeat (15) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
